// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit seven-segment scanner with a double-buffered frame,
// an anti-ghosting guard window, hex/BCD decode and leading-zero blanking.
module seven_segment_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int GUARD          = 2,
   parameter int HEX_MODE       = 0,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF =
      (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
   logic                    pending_q, pending_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
   logic                    frame_done_q, frame_done_d;

   logic                    cnt_tc, idx_last, boundary;
   logic [3:0]              cur_code;
   logic                    cur_dp, cur_blank, zero_run;
   logic [NUM_DIGITS-1:0]   blank_vec, dig_onehot;
   logic [6:0]              seg_al;
   logic                    dp_al;

   // Decode table is expressed active-low; polarity is applied afterwards.
   function automatic logic [6:0] decode_al(input logic [3:0] code);
      logic [6:0] r;
      case (code)
         4'd0:    r = 7'b1000000;
         4'd1:    r = 7'b1111001;
         4'd2:    r = 7'b0100100;
         4'd3:    r = 7'b0110000;
         4'd4:    r = 7'b0011001;
         4'd5:    r = 7'b0010010;
         4'd6:    r = 7'b0000010;
         4'd7:    r = 7'b1111000;
         4'd8:    r = 7'b0000000;
         4'd9:    r = 7'b0010000;
         4'd10:   r = (HEX_MODE != 0) ? 7'b0001000 : 7'b1000000;
         4'd11:   r = (HEX_MODE != 0) ? 7'b0000011 : 7'b1000000;
         4'd12:   r = (HEX_MODE != 0) ? 7'b1000110 : 7'b1000000;
         4'd13:   r = (HEX_MODE != 0) ? 7'b0100001 : 7'b1000000;
         4'd14:   r = (HEX_MODE != 0) ? 7'b0000110 : 7'b1000000;
         default: r = (HEX_MODE != 0) ? 7'b0001110 : 7'b1000000;
      endcase
      return r;
   endfunction

   always_comb begin
      cnt_tc   = (cnt_q == CNT_W'(SCAN_DIV - 1));
      idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
      boundary = cnt_tc && idx_last;

      cnt_d = cnt_tc ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_tc) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);

      shadow_d    = load ? digits_in : shadow_q;
      shadow_dp_d = load ? dp_in : shadow_dp_q;
      active_d    = active_q;
      active_dp_d = active_dp_q;
      pending_d   = pending_q;
      // A load landing on the boundary itself bypasses the shadow buffer.
      if (boundary) begin
         pending_d = 1'b0;
         if (load) begin
            active_d    = digits_in;
            active_dp_d = dp_in;
         end else if (pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
         end
      end else if (load) begin
         pending_d = 1'b1;
      end

      zero_run  = 1'b1;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run     = zero_run && (active_q[4*i +: 4] == 4'd0);
         blank_vec[i] = blank_lz && zero_run;
      end

      cur_code   = 4'd0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      dig_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_code      = active_q[4*i +: 4];
            cur_dp        = active_dp_q[i];
            cur_blank     = blank_vec[i];
            dig_onehot[i] = (cnt_q >= CNT_W'(GUARD));
         end
      end

      seg_al       = cur_blank ? 7'h7F : decode_al(cur_code);
      dp_al        = cur_blank ? 1'b1 : ~cur_dp;
      seg_d        = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
      dp_d         = (SEG_ACTIVE_LOW != 0) ? dp_al : ~dp_al;
      dig_en_d     = (DIG_ACTIVE_LOW != 0) ? ~dig_onehot : dig_onehot;
      frame_done_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         active_q     <= '0;
         active_dp_q  <= '0;
         pending_q    <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         dig_en_q     <= DIG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         active_q     <= active_d;
         active_dp_q  <= active_dp_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         dig_en_q     <= dig_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign dig_en     = dig_en_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a frame of 4-bit digit codes plus decimal points and scans one digit at a time with a programmable dwell and anti-ghosting guard. New values are double-buffered and committed only at frame boundaries, so the display never tears. It supports hex or BCD decode, leading-zero blanking and selectable output polarity. It sits between the counter/encoder logic and the board display pins, and supersedes the single-digit combinational decoder.

## Interface
- NUM_DIGITS, 4: number of digits scanned, 1..8; digit 0 is least significant.
- SCAN_DIV, 50000: clock cycles per digit slot; must be greater than GUARD+1.
- GUARD, 2: cycles at the start of each slot with all digit enables off.
- HEX_MODE, 0: 1 decodes codes 10-15 as A,b,C,d,E,F; 0 decodes codes 10-15 as "0".
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit by 0.
- DIG_ACTIVE_LOW, 1: 1 means a digit is enabled by 0.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- digits_in  in  4*NUM_DIGITS  digit codes; digit i occupies bits [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- load  in  1  captures digits_in/dp_in into the shadow buffer.
- blank_lz  in  1  enables leading-zero blanking.
- seg_out  out  7  segments {g,f,e,d,c,b,a}.
- dp_out  out  1  decimal point of the current digit.
- dig_en  out  NUM_DIGITS  one-hot digit enables.
- frame_done  out  1  one-cycle pulse at each frame commit.

## Operation
- State: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), shadow buffer, active buffer, pending flag.
- cnt increments every cycle. At cnt==SCAN_DIV-1 (terminal count, TC), cnt goes to 0 and idx goes to idx+1, wrapping from NUM_DIGITS-1 to 0.
- A frame boundary is TC with idx==NUM_DIGITS-1.
- load=1 writes the shadow buffer and sets pending. Repeated loads overwrite; the last value wins.
- Commit: at a frame boundary with pending=1, active is set from shadow and pending is cleared.
- If load and a frame boundary occur in the same cycle, the active buffer takes digits_in/dp_in directly and pending ends at 0.
- Decode, shown active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Hex decode, shown active-low: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- For active-high segments, seg_out and dp_out are the bitwise inverse of the above.
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and active codes i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
- A blanked digit drives all segments off and dp off, but its dig_en still scans.
- dig_en[idx] is asserted only while cnt>=GUARD; all other enables are off.

## Timing
- All outputs are registered and lag the (cnt, idx, active) state by exactly 1 cycle.
- Reset (rst_n=0 sampled on a clk edge) sets the following:
  - cnt=0, idx=0, pending=0, shadow=0, active=0.
  - seg_out = all segments off (1111111 when active-low).
  - dp_out off; dig_en all off; frame_done=0.
- Reset mid-frame or mid-load aborts everything. A load sampled in the same cycle as reset is discarded.
- After reset release, the first enable asserts GUARD+1 cycles later.
- seg_out/dp_out change on the cycle after TC, while dig_en is all off. This makes the guard the no-ghost window.
- frame_done asserts for 1 cycle, 1 cycle after every frame boundary, whether or not a commit happened.
- A committed value is visible starting at digit 0 of the next frame. Worst-case load-to-display latency is NUM_DIGITS*SCAN_DIV+1 cycles.
- Frame period is NUM_DIGITS*SCAN_DIV cycles. Each enable is high for SCAN_DIV-GUARD cycles per frame.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, HEX_MODE=1, both polarities active-low.
- Reset then idle:
  - Every slot shows digit "0" (1000000).
  - dig_en cycles 1110, 1101, 1011, 0111, each low for 6 of 8 cycles.
  - frame_done pulses every 32 cycles.
- load 0x1A3F with dp_in=0010 in the middle of a frame:
  - Outputs are unchanged until the frame boundary.
  - The next frame shows F=0001110, 3=0110000, A=0001000, 1=1111001.
  - dp_out is 0 only in the digit-1 slot.
- blank_lz=1 with active 0x0040:
  - Digits 3 and 2 show 1111111.
  - Digit 1 shows 4=0011001; digit 0 shows "0".
  - With 0x0000, only digit 0 is lit.
- load 0x1234 followed by load 0x5678 in the same frame:
  - Only 5678 is ever displayed.
- load 0x9999 exactly on the TC cycle of digit 3:
  - 9999 appears at digit 0 of the next slot with no extra frame delay.
  - pending=0 afterwards.
- Assert rst_n=0 during the guard window of digit 2 with a pending load:
  - All outputs go off the next cycle.
  - After release, "0" is displayed and the pending value is lost.
